// File: rtl/maze_pkg.sv
// Shared definitions for the maze frame renderer: colours, screen size, FSM states
// and the pixel colour priority.
package maze_pkg;

    localparam logic [15:0] COL_BORDER = 16'h001F;
    localparam logic [15:0] COL_PLAYER = 16'hF800;
    localparam logic [15:0] COL_WALL   = 16'h0000;
    localparam logic [15:0] COL_PATH   = 16'h07E0;

    localparam int unsigned SCREEN_W_DEF = 240;
    localparam int unsigned SCREEN_H_DEF = 320;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MAZE,
        S_LATCH,
        S_DRAW,
        S_DONE
    } renderState_t;

    // Border beats player beats wall beats path.
    function automatic logic [15:0] pickColour(input logic inMaze,
                                               input logic isPlayer,
                                               input logic isWall);
        logic [15:0] c;
        if (!inMaze)
            c = COL_BORDER;
        else if (isPlayer)
            c = COL_PLAYER;
        else if (isWall)
            c = COL_WALL;
        else
            c = COL_PATH;
        return c;
    endfunction

endpackage

// File: rtl/maze_raster_counter.sv
// One raster axis: pixel position, sub-pixel position within a tile and tile index.
// The tile index is kept incrementally so no divider is needed.
module maze_raster_counter #(
    parameter int unsigned SIZE = 240,
    parameter int unsigned TILE = 8,
    parameter int unsigned W    = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] pixel,
    output logic [W-1:0] tile,
    output logic         last
);

    localparam int unsigned SUB_W = (TILE > 1) ? $clog2(TILE) : 1;

    logic [SUB_W-1:0] sub;

    assign last = (pixel == W'(SIZE - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pixel <= '0;
            sub   <= '0;
            tile  <= '0;
        end else if (clear) begin
            pixel <= '0;
            sub   <= '0;
            tile  <= '0;
        end else if (advance) begin
            if (last) begin
                pixel <= '0;
                sub   <= '0;
                tile  <= '0;
            end else begin
                pixel <= pixel + 1'b1;
                if (sub == SUB_W'(TILE - 1)) begin
                    sub  <= '0;
                    tile <= tile + 1'b1;
                end else begin
                    sub <= sub + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/maze_frame_renderer.sv
// Streams one full LT24 frame of the latched maze, player tile highlighted, over the
// xAddr/yAddr/pixelData/pixelWrite/pixelReady handshake.
module maze_frame_renderer #(
    parameter int unsigned MAZE_W   = 10,
    parameter int unsigned MAZE_H   = 10,
    parameter int unsigned TILE     = 8,
    parameter int unsigned SCREEN_W = maze_pkg::SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = maze_pkg::SCREEN_H_DEF
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [MAZE_W*MAZE_H-1:0]   maze,
    input  logic                       mazeValid,
    input  logic                       start,
    input  logic [3:0]                 playerX,
    input  logic [3:0]                 playerY,
    output logic [7:0]                 xAddr,
    output logic [8:0]                 yAddr,
    output logic [15:0]                pixelData,
    output logic                       pixelWrite,
    input  logic                       pixelReady,
    output logic                       busy,
    output logic                       frameDone
);

    import maze_pkg::*;

    localparam int unsigned CELLS = MAZE_W * MAZE_H;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    renderState_t       state;
    logic [CELLS-1:0]   mazeQ;
    logic [3:0]         playerXQ;
    logic [3:0]         playerYQ;
    logic               lastLoaded;

    logic [7:0]         xPix;
    logic [7:0]         xTile;
    logic               xLast;
    logic [8:0]         yPix;
    logic [8:0]         yTile;
    logic               yLast;

    logic               counterClear;
    logic               loadPixel;
    logic               finalAccept;

    logic               inMaze;
    logic               isPlayer;
    logic               isWall;
    logic [IDX_W-1:0]   cellIdx;
    logic [15:0]        colour;

    // Counters run one pixel ahead of the outputs, so the next pixel is ready on acceptance.
    assign counterClear = (state == S_LATCH);
    assign finalAccept  = (state == S_DRAW) && pixelWrite && pixelReady && lastLoaded;
    assign loadPixel    = (state == S_DRAW) && (!pixelWrite || pixelReady) && !finalAccept;

    maze_raster_counter #(
        .SIZE (SCREEN_W),
        .TILE (TILE),
        .W    (8)
    ) xCounter (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (counterClear),
        .advance (loadPixel),
        .pixel   (xPix),
        .tile    (xTile),
        .last    (xLast)
    );

    maze_raster_counter #(
        .SIZE (SCREEN_H),
        .TILE (TILE),
        .W    (9)
    ) yCounter (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (counterClear),
        .advance (loadPixel && xLast),
        .pixel   (yPix),
        .tile    (yTile),
        .last    (yLast)
    );

    // An out-of-range player can only match a tile outside the maze, where border wins.
    always_comb begin
        inMaze   = (32'(xTile) < MAZE_W) && (32'(yTile) < MAZE_H);
        isPlayer = (32'(xTile) == 32'(playerXQ)) && (32'(yTile) == 32'(playerYQ));
        cellIdx  = IDX_W'(32'(yTile) * MAZE_W + 32'(xTile));
        isWall   = mazeQ[cellIdx];
        colour   = pickColour(inMaze, isPlayer, isWall);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            mazeQ      <= '0;
            playerXQ   <= '0;
            playerYQ   <= '0;
            lastLoaded <= 1'b0;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelData  <= '0;
            pixelWrite <= 1'b0;
            busy       <= 1'b0;
            frameDone  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    frameDone <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        state <= mazeValid ? S_LATCH : S_WAIT_MAZE;
                    end
                end
                S_WAIT_MAZE: begin
                    if (mazeValid)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    mazeQ      <= maze;
                    playerXQ   <= playerX;
                    playerYQ   <= playerY;
                    lastLoaded <= 1'b0;
                    state      <= S_DRAW;
                end
                S_DRAW: begin
                    if (finalAccept) begin
                        pixelWrite <= 1'b0;
                        busy       <= 1'b0;
                        frameDone  <= 1'b1;
                        state      <= S_DONE;
                    end else if (loadPixel) begin
                        xAddr      <= xPix;
                        yAddr      <= yPix;
                        pixelData  <= colour;
                        pixelWrite <= 1'b1;
                        lastLoaded <= xLast && yLast;
                    end
                end
                S_DONE: begin
                    frameDone <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
